// File: rtl/alu_instr_encoder_if.sv
// Request/response bundle for the ALU instruction encoder: request fields in,
// encoded RV32I word out, each side with a valid/ready handshake.
interface alu_instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic        in_is_imm;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [12:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;

    modport master (
        output in_valid, in_op, in_is_imm, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr
    );

    modport slave (
        input  in_valid, in_op, in_is_imm, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr
    );
endinterface

// File: rtl/alu_instr_encoder.sv
// Encodes ALU/branch requests into RV32I words, queues legal ones in a small FIFO
// and counts illegal requests with a saturating counter.
module alu_instr_encoder #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_instr_encoder_if.slave bus,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        is_branch;
    logic        is_shift;
    logic        illegal;
    logic [31:0] instr;

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [31:0]      mem_q [DEPTH];
    logic [31:0]      mem_d [DEPTH];
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic in_ready_int;
    logic out_valid_int;
    logic accept;
    logic push;
    logic pop;

    always_comb begin
        f3        = 3'b000;
        f7        = 7'b0000000;
        is_branch = 1'b0;
        is_shift  = 1'b0;
        illegal   = 1'b0;
        case (bus.in_op)
            4'b0000: f3 = 3'b111;
            4'b0001: f3 = 3'b110;
            4'b0010: f3 = 3'b000;
            4'b0011: begin f3 = 3'b000; f7 = 7'b0100000; end
            4'b0100: begin f3 = 3'b001; is_shift = 1'b1; end
            4'b0101: f3 = 3'b010;
            4'b0110: f3 = 3'b100;
            4'b0111: begin f3 = 3'b101; is_shift = 1'b1; end
            4'b1000: begin f3 = 3'b101; f7 = 7'b0100000; is_shift = 1'b1; end
            4'b1100: f3 = 3'b011;
            4'b1010: begin f3 = 3'b000; is_branch = 1'b1; end
            4'b1011: begin f3 = 3'b001; is_branch = 1'b1; end
            default: illegal = 1'b1;
        endcase
        // There is no SUBI in RV32I; branch offsets must be halfword aligned.
        if (bus.in_op == 4'b0011 && bus.in_is_imm) illegal = 1'b1;
        if (is_branch && bus.in_imm[0]) illegal = 1'b1;
    end

    always_comb begin
        if (is_branch) begin
            instr = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, f3,
                     bus.in_imm[4:1], bus.in_imm[11], 7'b1100011};
        end else if (bus.in_is_imm) begin
            instr = {(is_shift ? f7 : bus.in_imm[11:5]), bus.in_imm[4:0], bus.in_rs1, f3,
                     bus.in_rd, 7'b0010011};
        end else begin
            instr = {f7, bus.in_rs2, bus.in_rs1, f3, bus.in_rd, 7'b0110011};
        end
    end

    assign in_ready_int  = (count_q < FullCnt);
    assign out_valid_int = (count_q != '0);
    assign accept        = bus.in_valid && in_ready_int;
    assign push          = accept && !illegal;
    assign pop           = out_valid_int && bus.out_ready;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        mem_d       = mem_q;
        err_pulse_d = accept && illegal;
        err_count_d = err_count_q;
        if (push) begin
            mem_d[wr_ptr_q] = instr;
            wr_ptr_d        = PtrW'(wr_ptr_q + PtrW'(1));
        end
        if (pop) rd_ptr_d = PtrW'(rd_ptr_q + PtrW'(1));
        case ({push, pop})
            2'b10:   count_d = CntW'(count_q + CntW'(1));
            2'b01:   count_d = CntW'(count_q - CntW'(1));
            default: count_d = count_q;
        endcase
        if (accept && illegal && err_count_q != '1) begin
            err_count_d = ERR_W'(err_count_q + ERR_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    // Storage needs no reset: occupancy gates visibility of every entry.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_int;
    assign bus.out_instr = mem_q[rd_ptr_q];
    assign err_pulse     = err_pulse_q;
    assign err_count     = err_count_q;
endmodule

// File: tb/tb_alu_instr_encoder.sv
// Self-checking bench for alu_instr_encoder: directed cases with known words
// plus a randomized run against a table-driven reference model.
module tb_alu_instr_encoder;
    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       err_pulse;
    logic [7:0] err_count;
    int         n_cmp = 0;
    int         n_bad = 0;

    // funct3 per opcode; -1 marks an opcode with no encoding.
    int f3_tab [16] = '{7, 6, 0, 0, 1, 2, 4, 5, 5, -1, 0, 1, 3, -1, -1, -1};

    alu_instr_encoder_if bus ();

    alu_instr_encoder #(.DEPTH(DEPTH), .ERR_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    function automatic void ref_encode(input logic [3:0] op, input logic is_imm,
                                       input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [12:0] imm,
                                       output bit legal, output logic [31:0] word);
        int unsigned f3, alt, upper, im, w;
        bit          branch, shift;
        im     = imm;
        branch = (op == 10) || (op == 11);
        shift  = (op == 4) || (op == 7) || (op == 8);
        alt    = ((op == 3) || (op == 8)) ? 32 : 0;
        legal  = (f3_tab[op] >= 0) && !(op == 3 && is_imm) && !(branch && im % 2 == 1);
        f3     = (f3_tab[op] >= 0) ? f3_tab[op] : 0;
        if (branch) begin
            w = ((im >> 12) & 1) * 2**31 + ((im >> 5) & 63) * 2**25 + rs2 * 2**20
                + rs1 * 2**15 + f3 * 2**12 + ((im >> 1) & 15) * 2**8
                + ((im >> 11) & 1) * 2**7 + 'h63;
        end else if (is_imm) begin
            upper = shift ? alt * 32 + (im & 31) : (im & 'hFFF);
            w = upper * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + 'h13;
        end else begin
            w = alt * 2**25 + rs2 * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + 'h33;
        end
        word = w;
    endfunction

    task automatic set_req(input logic [3:0] op, input logic is_imm, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [12:0] imm);
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.in_is_imm = is_imm;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_imm    = imm;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp += 4;
        if (bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        if (bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        if (err_pulse !== 1'b0) begin
            n_bad++; $display("FAIL reset_err_pulse: got %b want 0", err_pulse);
        end
        if (err_count !== 8'd0) begin
            n_bad++; $display("FAIL reset_err_count: got %0d want 0", err_count);
        end
    endtask

    task automatic test_directed();
        logic [3:0]  t_op  [4] = '{4'd2, 4'd2, 4'd8, 4'd10};
        logic        t_imm [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [4:0]  t_rd  [4] = '{5'd1, 5'd5, 5'd1, 5'd0};
        logic [4:0]  t_rs1 [4] = '{5'd2, 5'd0, 5'd1, 5'd1};
        logic [4:0]  t_rs2 [4] = '{5'd3, 5'd0, 5'd0, 5'd2};
        logic [12:0] t_iv  [4] = '{13'd0, 13'h1FFF, 13'd3, 13'd8};
        logic [31:0] t_exp [4] = '{32'h003100B3, 32'hFFF00293, 32'h4030D093, 32'h00208463};
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(t_op[i], t_imm[i], t_rd[i], t_rs1[i], t_rs2[i], t_iv[i]);
            @(negedge clk);
            bus.in_valid = 1'b0;
            n_cmp += 2;
            if (bus.out_valid !== 1'b1) begin
                n_bad++; $display("FAIL dir%0d_valid: got %b want 1", i, bus.out_valid);
            end
            if (bus.out_instr !== t_exp[i]) begin
                n_bad++;
                $display("FAIL dir%0d_instr: got %h want %h", i, bus.out_instr, t_exp[i]);
            end
            @(negedge clk);
            n_cmp++;
            if (bus.out_valid !== 1'b0) begin
                n_bad++; $display("FAIL dir%0d_drain: got %b want 0", i, bus.out_valid);
            end
        end
        // Misaligned branch offset is rejected.
        set_req(4'd10, 1'b0, 5'd0, 5'd1, 5'd2, 13'd9);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_cmp += 3;
        if (bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL beq_odd_valid: got %b want 0", bus.out_valid);
        end
        if (err_pulse !== 1'b1) begin
            n_bad++; $display("FAIL beq_odd_pulse: got %b want 1", err_pulse);
        end
        if (err_count !== 8'd1) begin
            n_bad++; $display("FAIL beq_odd_count: got %0d want 1", err_count);
        end
        @(negedge clk);
        n_cmp++;
        if (err_pulse !== 1'b0) begin
            n_bad++; $display("FAIL beq_odd_pulse_clr: got %b want 0", err_pulse);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wa = 32'h003100B3;
        logic [31:0] wb = 32'h0062E233;
        logic [31:0] wc = 32'h12344393;
        do_reset();
        bus.out_ready = 1'b0;
        set_req(4'd2, 1'b0, 5'd1, 5'd2, 5'd3, 13'd0);
        @(negedge clk);
        set_req(4'd1, 1'b0, 5'd4, 5'd5, 5'd6, 13'd0);
        n_cmp += 2;
        if (bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL b2b_ready1: got %b want 1", bus.in_ready);
        end
        if (bus.out_instr !== wa) begin
            n_bad++; $display("FAIL b2b_head_a: got %h want %h", bus.out_instr, wa);
        end
        @(negedge clk);
        set_req(4'd6, 1'b1, 5'd7, 5'd8, 5'd0, 13'h123);
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_bad++; $display("FAIL b2b_full: got %b want 0", bus.in_ready);
        end
        @(negedge clk);
        n_cmp += 2;
        if (bus.in_ready !== 1'b0) begin
            n_bad++; $display("FAIL b2b_full_hold: got %b want 0", bus.in_ready);
        end
        if (bus.out_instr !== wa) begin
            n_bad++; $display("FAIL b2b_stable: got %h want %h", bus.out_instr, wa);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_cmp += 2;
        if (bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL b2b_ready_after_pop: got %b want 1", bus.in_ready);
        end
        if (bus.out_instr !== wb) begin
            n_bad++; $display("FAIL b2b_head_b: got %h want %h", bus.out_instr, wb);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_cmp += 2;
        if (bus.out_valid !== 1'b1) begin
            n_bad++; $display("FAIL b2b_valid_c: got %b want 1", bus.out_valid);
        end
        if (bus.out_instr !== wc) begin
            n_bad++; $display("FAIL b2b_head_c: got %h want %h", bus.out_instr, wc);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL b2b_empty: got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_saturation();
        int want;
        do_reset();
        bus.out_ready = 1'b1;
        set_req(4'd9, 1'b0, 5'd3, 5'd4, 5'd5, 13'd0);
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            want = (k > 255) ? 255 : k;
            n_cmp += 3;
            if (bus.out_valid !== 1'b0) begin
                n_bad++; $display("FAIL sat_valid@%0d: got %b want 0", k, bus.out_valid);
            end
            if (err_pulse !== 1'b1) begin
                n_bad++; $display("FAIL sat_pulse@%0d: got %b want 1", k, err_pulse);
            end
            if (err_count !== want[7:0]) begin
                n_bad++; $display("FAIL sat_count@%0d: got %0d want %0d", k, err_count, want);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset_full();
        do_reset();
        bus.out_ready = 1'b0;
        set_req(4'd15, 1'b0, 5'd0, 5'd0, 5'd0, 13'd0);
        @(negedge clk);
        set_req(4'd0, 1'b0, 5'd9, 5'd10, 5'd11, 13'd0);
        @(negedge clk);
        set_req(4'd5, 1'b1, 5'd12, 5'd13, 5'd0, 13'h7F);
        @(negedge clk);
        n_cmp += 3;
        if (bus.in_ready !== 1'b0) begin
            n_bad++; $display("FAIL rf_full: got %b want 0", bus.in_ready);
        end
        if (bus.out_valid !== 1'b1) begin
            n_bad++; $display("FAIL rf_valid: got %b want 1", bus.out_valid);
        end
        if (err_count !== 8'd1) begin
            n_bad++; $display("FAIL rf_count: got %0d want 1", err_count);
        end
        // Reset with a pending push and pop in the same cycle.
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        set_req(4'd2, 1'b0, 5'd1, 5'd1, 5'd1, 13'd0);
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        n_cmp += 4;
        if (bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL rf_rst_valid: got %b want 0", bus.out_valid);
        end
        if (bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL rf_rst_ready: got %b want 1", bus.in_ready);
        end
        if (err_count !== 8'd0) begin
            n_bad++; $display("FAIL rf_rst_count: got %0d want 0", err_count);
        end
        if (err_pulse !== 1'b0) begin
            n_bad++; $display("FAIL rf_rst_pulse: got %b want 0", err_pulse);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL rf_post_valid: got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_q [$];
        logic [31:0] word;
        bit          legal, v, ordy, exp_pulse;
        int          exp_cnt;
        logic [3:0]  op;
        logic [12:0] imm;
        do_reset();
        exp_pulse = 1'b0;
        exp_cnt   = 0;
        for (int c = 0; c < 3000; c++) begin
            v    = ($urandom_range(0, 2) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            op   = 4'($urandom_range(0, 15));
            imm  = 13'($urandom);
            if ((op == 10 || op == 11) && $urandom_range(0, 3) != 0) imm[0] = 1'b0;
            set_req(op, 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm);
            bus.in_valid  = v;
            bus.out_ready = ordy;
            exp_pulse     = 1'b0;
            if (v && exp_q.size() < DEPTH) begin
                ref_encode(op, bus.in_is_imm, bus.in_rd, bus.in_rs1, bus.in_rs2, imm,
                           legal, word);
                if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
                if (legal) exp_q.push_back(word);
                else begin
                    exp_pulse = 1'b1;
                    if (exp_cnt < 255) exp_cnt++;
                end
            end else if (exp_q.size() != 0 && ordy) begin
                void'(exp_q.pop_front());
            end
            @(negedge clk);
            n_cmp += 4;
            if (bus.out_valid !== (exp_q.size() != 0)) begin
                n_bad++;
                $display("FAIL rnd_valid@%0d: got %b want %b", c, bus.out_valid,
                         exp_q.size() != 0);
            end
            if (bus.in_ready !== (exp_q.size() < DEPTH)) begin
                n_bad++;
                $display("FAIL rnd_ready@%0d: got %b want %b", c, bus.in_ready,
                         exp_q.size() < DEPTH);
            end
            if (err_pulse !== exp_pulse) begin
                n_bad++; $display("FAIL rnd_pulse@%0d: got %b want %b", c, err_pulse, exp_pulse);
            end
            if (err_count !== exp_cnt[7:0]) begin
                n_bad++;
                $display("FAIL rnd_count@%0d: got %0d want %0d", c, err_count, exp_cnt);
            end
            if (exp_q.size() != 0) begin
                n_cmp++;
                if (bus.out_instr !== exp_q[0]) begin
                    n_bad++;
                    $display("FAIL rnd_instr@%0d: got %h want %h", c, bus.out_instr, exp_q[0]);
                end
            end
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_op     = 4'd0;
        bus.in_is_imm = 1'b0;
        bus.in_rd     = 5'd0;
        bus.in_rs1    = 5'd0;
        bus.in_rs2    = 5'd0;
        bus.in_imm    = 13'd0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        test_saturation();
        test_reset_full();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
